// File: rtl/addr_bus_sequencer.sv
// ---------------------------------------------------------------------------
// addr_bus_sequencer
//
// Arbiter and sequencer for the shared 16-bit address bus. Four requesters
// (PC, M pair, J pair, XY) contend for the bus. One is granted per
// transaction in round-robin order. Its select is raised, the memory strobe
// is timed with settle and hold margins, and a one-cycle done pulse is
// returned to it.
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   req      in   4  level-held requests [0]=PC [1]=M [2]=J [3]=XY
//   req_wr   in   4  per-requester op select, 1=write 0=read
//   sel      out  4  one-hot address-bus driver select (or zero)
//   mem_rd   out  1  memory read strobe
//   mem_wr   out  1  memory write strobe
//   done     out  4  one-cycle completion pulse to the granted requester
//   busy     out  1  high whenever the FSM is not idle
//
// Every output comes straight from a flop. There is no combinational path
// from req or req_wr to the outputs.
// ---------------------------------------------------------------------------
module addr_bus_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,  // legal 1..15
  parameter int unsigned STROBE_CYCLES = 3   // legal 1..15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] req_wr,
  output logic [3:0] sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [3:0] done,
  output logic       busy
);

  // Counter reload values. With the legal parameter range these always fit
  // in 4 bits, and the counter only ever counts down to zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t     state_reg,  state_next;
  logic [3:0] cnt_reg,    cnt_next;
  logic [1:0] rr_ptr_reg, rr_ptr_next;
  logic [1:0] gnt_reg,    gnt_next;
  logic       op_reg,     op_next;

  logic [3:0] sel_reg,    sel_next;
  logic       mem_rd_reg, mem_rd_next;
  logic       mem_wr_reg, mem_wr_next;
  logic [3:0] done_reg,   done_next;
  logic       busy_reg,   busy_next;

  // -------------------------------------------------------------------------
  // Round-robin search. The request vector is rotated so that bit 0 is the
  // requester at rr_ptr. A fixed-priority pick on the rotated vector then
  // gives the offset from rr_ptr. The 2-bit sum wraps 3->0 naturally.
  // -------------------------------------------------------------------------
  logic [3:0] req_rot;
  logic [1:0] rot_idx;
  logic [1:0] grant_idx;
  logic       req_any;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[rr_ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    rot_idx = 2'd0;
    if (req_rot[0])      rot_idx = 2'd0;
    else if (req_rot[1]) rot_idx = 2'd1;
    else if (req_rot[2]) rot_idx = 2'd2;
    else                 rot_idx = 2'd3;
  end

  assign req_any   = |req_rot;
  assign grant_idx = rr_ptr_reg + rot_idx;

  // One-hot decode of the grant that will be held in the coming cycle.
  logic [3:0] gnt_onehot;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign gnt_onehot[gi] = (gnt_next == 2'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_next    = gnt_reg;
    op_next     = op_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          // g and op are latched here. Later changes on req and req_wr
          // cannot disturb the transaction.
          gnt_next   = grant_idx;
          op_next    = req_wr[grant_idx];
          cnt_next   = SETTLE_LOAD;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (cnt_reg == 4'd0) begin
          cnt_next   = STROBE_LOAD;
          state_next = ST_STROBE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RELEASE: begin
        // The pointer advances on entry to DONE, so it is ready before the
        // next IDLE search.
        rr_ptr_next = gnt_reg + 2'd1;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output pre-decode. Outputs are computed from the next state and
  // registered. The visible outputs therefore line up with the state the
  // FSM is in during that cycle, with no combinational input-to-output path.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_next    = 4'd0;
    mem_rd_next = 1'b0;
    mem_wr_next = 1'b0;
    done_next   = 4'd0;
    busy_next   = (state_next != ST_IDLE);

    case (state_next)
      ST_SELECT, ST_RELEASE: begin
        sel_next = gnt_onehot;
      end
      ST_STROBE: begin
        sel_next    = gnt_onehot;
        mem_wr_next = op_next;
        mem_rd_next = ~op_next;
      end
      ST_DONE: begin
        done_next = gnt_onehot;
      end
      default: begin
        sel_next = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers. The asynchronous reset clears sel and the
  // strobes immediately. An aborted transaction never reaches DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      rr_ptr_reg <= 2'd0;
      gnt_reg    <= 2'd0;
      op_reg     <= 1'b0;
      sel_reg    <= 4'd0;
      mem_rd_reg <= 1'b0;
      mem_wr_reg <= 1'b0;
      done_reg   <= 4'd0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_reg    <= gnt_next;
      op_reg     <= op_next;
      sel_reg    <= sel_next;
      mem_rd_reg <= mem_rd_next;
      mem_wr_reg <= mem_wr_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
    end
  end

  assign sel    = sel_reg;
  assign mem_rd = mem_rd_reg;
  assign mem_wr = mem_wr_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;

endmodule
